// File: rtl/seq_detect_ctrl_if.sv
// Word handshake between a bus-side producer and the serial pattern detector.
// The producer drives valid/data; the controller answers with ready.
interface seq_detect_ctrl_if #(
    parameter int unsigned WORD_W = 8
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serializes accepted words MSB-first into a programmable overlapping pattern
// detector, counts matches and raises a sticky threshold interrupt.
module seq_detect_ctrl #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_ctrl_if.slave   bus,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               irq_clr,
    output logic               busy,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               irq
);
    localparam int unsigned BC_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [3:0]  PAT_MAX_L = 4'(PAT_MAX);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [WORD_W-1:0]  word;
    logic [BC_W-1:0]    bit_cnt;
    logic [PAT_MAX-1:0] pattern;
    logic [PAT_MAX-1:0] history;
    logic [3:0]         len;
    logic [3:0]         fill;
    logic [CNT_W-1:0]   thresh;

    logic               accept;
    logic               cfg_ok;
    logic [3:0]         len_cfg;
    logic [PAT_MAX-1:0] hist_next;
    logic [3:0]         fill_next;
    logic [PAT_MAX-1:0] len_mask;
    logic               hit;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_next;
    logic               thresh_hit;

    // Ready on the last bit of a word as well, so consecutive words stream without a bubble
    assign bus.in_ready = !rst && (state == IDLE || bit_cnt == '0);
    assign accept       = bus.in_valid && bus.in_ready;
    assign cfg_ok       = cfg_we && (state == IDLE) && !accept;

    always_comb begin
        len_cfg    = cfg_len;
        if (cfg_len == 4'd0)
            len_cfg = 4'd1;
        else if (cfg_len > PAT_MAX_L)
            len_cfg = PAT_MAX_L;

        hist_next  = {history[PAT_MAX-2:0], word[bit_cnt]};
        fill_next  = (fill == PAT_MAX_L) ? fill : fill + 4'd1;
        len_mask   = ~({PAT_MAX{1'b1}} << len);
        hit        = (fill_next >= len) && (((hist_next ^ pattern) & len_mask) == '0);

        // A clear takes effect before a coincident pulse is counted
        cnt_base   = irq_clr ? '0 : match_count;
        cnt_next   = (match_pulse && cnt_base != '1) ? cnt_base + CNT_W'(1) : cnt_base;
        thresh_hit = match_pulse && (thresh != '0) && (cnt_next == thresh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word        <= '0;
            bit_cnt     <= '0;
            pattern     <= '0;
            history     <= '0;
            len         <= 4'd1;
            fill        <= '0;
            thresh      <= '0;
            busy        <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= '0;
            irq         <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            match_count <= cnt_next;
            irq         <= (irq && !irq_clr) || thresh_hit;

            if (cfg_ok) begin
                pattern <= cfg_pattern;
                len     <= len_cfg;
                thresh  <= cfg_thresh;
                history <= '0;
                fill    <= '0;
            end

            if (state == SHIFT) begin
                history     <= hist_next;
                fill        <= fill_next;
                match_pulse <= hit;
                if (bit_cnt != '0)
                    bit_cnt <= bit_cnt - BC_W'(1);
            end

            if (accept) begin
                word    <= bus.in_data;
                bit_cnt <= BC_W'(WORD_W - 1);
                state   <= SHIFT;
                busy    <= 1'b1;
            end else if (state == SHIFT && bit_cnt == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Streaming controller for a programmable serial pattern detector.
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per cycle, into an internal Moore-style detector.
- The detector matches a software-configured pattern of 1..PAT_MAX bits, with overlapping matches allowed.
- Counts matches and raises a sticky interrupt when the count reaches a programmed threshold; sits between a bus-side producer and the detection datapath.

Parameters:
WORD_W, 8, input word width (bits serialized per word)
PAT_MAX, 8, maximum pattern length in bits
CNT_W, 8, match counter / threshold width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_we  in  1  config write strobe; honoured only in IDLE with no handshake in the same cycle
cfg_pattern  in  PAT_MAX  pattern; bit len-1 is the first bit received, bit 0 the last
cfg_len  in  4  pattern length; 0 treated as 1, >PAT_MAX clamped to PAT_MAX
cfg_thresh  in  CNT_W  interrupt threshold; 0 disables irq
in_valid  in  1  producer has a word
in_data  in  WORD_W  word to serialize
in_ready  out  1  controller accepts a word this cycle
busy  out  1  high while in SHIFT
match_pulse  out  1  one-cycle pulse per detected match
match_count  out  CNT_W  saturating match count
irq  out  1  sticky threshold interrupt
irq_clr  in  1  clears irq and match_count

Behaviour:
- Reset: state=IDLE, pattern=0, len=1, thresh=0, history=0, fill=0, bit_cnt=0, match_pulse=0, match_count=0, irq=0, busy=0. in_ready is forced low while rst=1.
- States: IDLE, SHIFT.
- in_ready = !rst && (state==IDLE || (state==SHIFT && bit_cnt==0)).
- Accept: in_valid && in_ready. The word is latched, state becomes/stays SHIFT, and bit_cnt=WORD_W-1.
- SHIFT, each cycle:
  - history <= {history[PAT_MAX-2:0], word[bit_cnt]}; fill increments and saturates at PAT_MAX.
  - bit_cnt decrements.
  - On the bit_cnt==0 cycle without an accept: go to IDLE.
- Back-to-back words therefore stream with no bubble: WORD_W cycles per word.
- Match, registered: match_pulse is high the cycle after a shift when fill (post-shift) >= len and history[len-1:0]==pattern[len-1:0]. Overlaps are allowed; history is not cleared on a match.
- Counter: match_count increments on each match_pulse and saturates at 2^CNT_W-1.
- Interrupt: irq sets in the cycle match_count becomes equal to thresh (thresh!=0). It stays set until irq_clr.
- irq_clr clears irq and match_count.
  - irq_clr with a coincident match_pulse: the clear applies first, then the pulse counts, so match_count=1.
  - irq is re-evaluated against the new count.
- Config write in IDLE loads pattern/len/thresh and clears history and fill. It does not clear match_count or irq.
- cfg_we in SHIFT, or in the same cycle as an accept, is ignored (no effect).
- Reset mid-SHIFT aborts the current word. Bits not yet shifted are discarded, and no match_pulse follows reset.
- in_data is sampled only at accept; later changes have no effect.

Test Plan:
- Config pattern=5'b11011, len=5, thresh=2; send word 8'b1101_1011 -> in_ready low for cycles 1..7 of SHIFT; match_pulse after bit 5 and bit 8 (overlap); match_count=2; irq=1 after second pulse.
- Same config, two back-to-back words 8'hFF, 8'hFF with in_valid held -> in_ready high exactly once between them; 16 SHIFT cycles contiguous; match_pulse=0 throughout; count unchanged.
- Pattern=1'b1, len=0 (treated as 1), thresh=0; word 8'hA5 -> 4 match_pulses (bits 1,3,6,8); count=4; irq stays 0.
- CNT_W=8 saturation: len=1, pattern=1, send 33 words of 8'hFF -> match_count stops at 255; then assert irq_clr on a pulse cycle -> match_count=1.
- Reset asserted on the 3rd SHIFT cycle of word 8'b1101_1011 (len=5, pattern 11011) -> all outputs at reset values next cycle; no match_pulse.
- cfg_we with len=3 during SHIFT -> ignored; detection continues with len=5. Same write in IDLE -> applied; history cleared, so the first match needs 3 new bits.
